// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: stall encodings,
// multi-cycle FSM state codes and the Stop/NoStop and delay-slot constants.
package pipeline_ctrl_pkg;

  // Stall vector bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic STOP              = 1'b1;
  localparam logic NO_STOP           = 1'b0;
  localparam logic IN_DELAY_SLOT     = 1'b1;
  localparam logic NOT_IN_DELAY_SLOT = 1'b0;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipeline_ctrl_mc_timer.sv
// Loadable down-counter with clear, load, enable and zero flag; timing source
// for multi-cycle ex operations (also usable by a future hilo/div unit).
module pipeline_ctrl_mc_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear beats load beats decrement; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall sequencer: merges id hazards with multi-cycle ex operations,
// drives the per-stage stall vector, delay-slot flag and stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 34,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              mc_start,
  input  logic              mc_is_div,
  input  logic              mc_cancel,
  input  logic              branch_flag_i,
  output logic [5:0]        stall,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              next_inst_in_delayslot_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output mc_state_e         dbg_state_o
);

  localparam logic [CNT_W-1:0]  MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;

  mc_state_e         state_q, state_d;
  logic              mc_busy_q, mc_done_q;
  logic              ds_q;
  logic [PERF_W-1:0] stall_cycles_q;
  logic              tmr_load, tmr_en, tmr_clear, tmr_zero;
  logic [CNT_W-1:0]  tmr_load_val, tmr_cnt;
  logic              ex_stall;

  assign tmr_load_val = mc_is_div ? DIV_LOAD : MULT_LOAD;

  pipeline_ctrl_mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // MC_RUN lasts load-value cycles; a zero load (2-cycle op) skips it entirely.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_clear = 1'b0;
    if (mc_cancel) begin
      state_d   = MC_IDLE;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (mc_start) begin
            tmr_load = 1'b1;
            state_d  = (tmr_load_val == '0) ? MC_DONE : MC_RUN;
          end
        end
        MC_RUN: begin
          tmr_en = 1'b1;
          if (tmr_zero || (tmr_cnt == CNT_W'(1))) begin
            state_d = MC_DONE;
          end
        end
        MC_DONE: state_d = MC_IDLE;
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MC_IDLE;
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_busy_q <= (state_d == MC_RUN);
      mc_done_q <= (state_d == MC_DONE);
    end
  end

  assign ex_stall = ((state_q == MC_IDLE) && mc_start && !mc_cancel) ||
                    ((state_q == MC_RUN) && !mc_cancel);

  always_comb begin
    stall = STALL_NONE;
    if (!rst) begin
      if (ex_stall) begin
        stall = STALL_EX;
      end else if (stallreq_from_id) begin
        stall = STALL_ID;
      end
    end
  end

  // A stalled id keeps its instruction, so the flag must not advance with it.
  always_ff @(posedge clk) begin
    if (rst || mc_cancel) begin
      ds_q <= NOT_IN_DELAY_SLOT;
    end else if (stall[2] == NO_STOP) begin
      ds_q <= branch_flag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if ((stall != STALL_NONE) && (stall_cycles_q != PERF_MAX)) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign mc_busy                  = mc_busy_q;
  assign mc_done                  = mc_done_q;
  assign next_inst_in_delayslot_o = ds_q;
  assign stall_cycles_o           = stall_cycles_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, mult, div with id request,
// cancel, delay-slot hold and stall-counter saturation.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        mc_start;
  logic        mc_is_div;
  logic        mc_cancel;
  logic        branch_flag_i;
  logic [5:0]  stall;
  logic        mc_busy;
  logic        mc_done;
  logic        next_inst_in_delayslot_o;
  logic [31:0] stall_cycles_o;
  mc_state_e   dbg_state_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (34),
    .CNT_W       (6),
    .PERF_W      (32)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .stallreq_from_id         (stallreq_from_id),
    .mc_start                 (mc_start),
    .mc_is_div                (mc_is_div),
    .mc_cancel                (mc_cancel),
    .branch_flag_i            (branch_flag_i),
    .stall                    (stall),
    .mc_busy                  (mc_busy),
    .mc_done                  (mc_done),
    .next_inst_in_delayslot_o (next_inst_in_delayslot_o),
    .stall_cycles_o           (stall_cycles_o),
    .dbg_state_o              (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_from_id = 1'b1; mc_start = 1'b1;
    mc_is_div = 1'b0; mc_cancel = 1'b0; branch_flag_i = 1'b0;
    next_cycle();

    // Reset held with live requests
    for (int i = 0; i < 3; i++) begin
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_busy", 32'(mc_busy), 32'h0);
      chk("rst_done", 32'(mc_done), 32'h0);
      chk("rst_perf", stall_cycles_o, 32'h0);
      chk("rst_ds", 32'(next_inst_in_delayslot_o), 32'h0);
      chk("rst_state", 32'(dbg_state_o), 32'(MC_IDLE));
      next_cycle();
    end

    rst = 1'b0; stallreq_from_id = 1'b0; mc_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_stall", 32'(stall), 32'h0);
      chk("idle_perf", stall_cycles_o, 32'h0);
      next_cycle();
    end

    // Multiply: stall cycles 0..2, done in cycle 3
    mc_start = 1'b1; mc_is_div = 1'b0;
    #0;
    chk("mult_c0_stall", 32'(stall), 32'h0f);
    chk("mult_c0_busy", 32'(mc_busy), 32'h0);
    next_cycle();
    mc_start = 1'b0;
    #0;
    for (int i = 1; i <= 2; i++) begin
      chk("mult_run_stall", 32'(stall), 32'h0f);
      chk("mult_run_busy", 32'(mc_busy), 32'h1);
      chk("mult_run_done", 32'(mc_done), 32'h0);
      next_cycle();
    end
    chk("mult_c3_stall", 32'(stall), 32'h0);
    chk("mult_c3_done", 32'(mc_done), 32'h1);
    chk("mult_c3_busy", 32'(mc_busy), 32'h0);
    chk("mult_c3_perf", stall_cycles_o, 32'd3);
    next_cycle();
    chk("mult_c4_done", 32'(mc_done), 32'h0);
    chk("mult_c4_state", 32'(dbg_state_o), 32'(MC_IDLE));
    chk("mult_c4_perf", stall_cycles_o, 32'd3);

    // Divide with id request held: 33 ex-stall cycles, then id-only in MC_DONE
    mc_start = 1'b1; mc_is_div = 1'b1; stallreq_from_id = 1'b1;
    #0;
    for (int k = 0; k <= 32; k++) begin
      chk("div_stall", 32'(stall), 32'h0f);
      chk("div_done_low", 32'(mc_done), 32'h0);
      if (k >= 1) chk("div_busy", 32'(mc_busy), 32'h1);
      next_cycle();
      mc_start = 1'b0;
      #0;
    end
    chk("div_c33_stall", 32'(stall), 32'h07);
    chk("div_c33_done", 32'(mc_done), 32'h1);
    chk("div_c33_busy", 32'(mc_busy), 32'h0);
    next_cycle();
    stallreq_from_id = 1'b0;
    #0;
    chk("div_c34_stall", 32'(stall), 32'h0);
    chk("div_c34_done", 32'(mc_done), 32'h0);
    chk("div_c34_perf", stall_cycles_o, 32'd37);
    next_cycle();

    // Cancel a divide on its 5th busy cycle
    mc_start = 1'b1; mc_is_div = 1'b1;
    #0;
    next_cycle();
    mc_start = 1'b0;
    for (int k = 1; k <= 4; k++) next_cycle();
    mc_cancel = 1'b1;
    #0;
    chk("cancel_busy_before", 32'(mc_busy), 32'h1);
    chk("cancel_stall", 32'(stall), 32'h0);
    next_cycle();
    mc_cancel = 1'b0;
    #0;
    chk("cancel_state", 32'(dbg_state_o), 32'(MC_IDLE));
    chk("cancel_busy", 32'(mc_busy), 32'h0);
    chk("cancel_stall_after", 32'(stall), 32'h0);
    for (int k = 0; k < 40; k++) begin
      chk("cancel_no_done", 32'(mc_done), 32'h0);
      next_cycle();
    end

    // Delay-slot flag held across an id stall, then captured
    chk("ds_init", 32'(next_inst_in_delayslot_o), 32'h0);
    branch_flag_i = 1'b1; stallreq_from_id = 1'b1;
    #0;
    chk("ds_stall_vec", 32'(stall), 32'h07);
    next_cycle();
    chk("ds_hold_1", 32'(next_inst_in_delayslot_o), 32'h0);
    next_cycle();
    chk("ds_hold_2", 32'(next_inst_in_delayslot_o), 32'h0);
    stallreq_from_id = 1'b0;
    next_cycle();
    chk("ds_capture", 32'(next_inst_in_delayslot_o), 32'h1);
    branch_flag_i = 1'b0; stallreq_from_id = 1'b1;
    next_cycle();
    chk("ds_hold_one", 32'(next_inst_in_delayslot_o), 32'h1);
    mc_cancel = 1'b1;
    next_cycle();
    mc_cancel = 1'b0; stallreq_from_id = 1'b0;
    chk("ds_cancel_clear", 32'(next_inst_in_delayslot_o), 32'h0);
    next_cycle();

    // Stall counter saturates at all-ones
    force dut.stall_cycles_q = 32'hffff_fffe;
    #1;
    release dut.stall_cycles_q;
    chk("sat_preload", stall_cycles_o, 32'hffff_fffe);
    stallreq_from_id = 1'b1;
    next_cycle();
    chk("sat_first", stall_cycles_o, 32'hffff_ffff);
    next_cycle();
    chk("sat_second", stall_cycles_o, 32'hffff_ffff);
    next_cycle();
    stallreq_from_id = 1'b0;
    chk("sat_third", stall_cycles_o, 32'hffff_ffff);
    next_cycle();
    chk("sat_hold", stall_cycles_o, 32'hffff_ffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
